// File: rtl/if_fetch_unit.sv
// Fetch-stage PC owner driving a 1-cycle-latency instruction BRAM; pc/valid align with BRAM data.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               imem_en_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus4_o,
    output logic               valid_o,
    output logic               misalign_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        TRAP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, next_pc, redirect_tgt;
    logic        valid_q, valid_d;
    logic        redirect_trap;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        redirect_trap = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect_tgt  = redirect_pc_i;
        redirect_trap = (redirect_pc_i[1:0] != 2'b00);
`else
        redirect_tgt  = redirect_pc_i & ~32'd3;
`endif
        next_pc = pc_q + 32'd4;
        state_d = state_q;
        valid_d = valid_q;

        if (rst) begin
            next_pc = RESET_PC;
            state_d = BOOT;
            valid_d = 1'b0;
        end else if (redirect_i) begin
            next_pc = redirect_tgt;
            state_d = redirect_trap ? TRAP : RUN;
            valid_d = 1'b1;
        end else begin
            case (state_q)
                BOOT: begin
                    next_pc = RESET_PC;
                    state_d = RUN;
                    valid_d = 1'b1;
                end
                TRAP: begin
                    next_pc = pc_q;
                end
                default: begin
                    // Re-presenting pc_q keeps the BRAM output stable while stalled.
                    if (stall_i) next_pc = pc_q;
                    valid_d = 1'b1;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= next_pc;
            valid_q <= valid_d;
        end
    end

    assign imem_addr_o = next_pc[IMEM_AW+1:2];
    assign imem_en_o   = rst | (state_q != TRAP);
    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_q + 32'd4;
    // A redirect kills whatever instruction is currently arriving from the BRAM.
    assign valid_o     = ~rst & valid_q & ~redirect_i;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_o = ~rst & (state_q == TRAP);
`else
    assign misalign_o = 1'b0;
`endif

endmodule
